adxl345_axis_assembler: RTL

//  Downstream of the ADXL345 SPI master. Collects the 6-byte DATAX0..DATAZ1 burst from the master's parallel MISO byte output.

---
 rtl/adxl345_axis_assembler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/adxl345_axis_assembler.sv
// adxl345_axis_assembler
//   Collects the 6-byte DATAX0..DATAZ1 burst delivered by the ADXL345 SPI
//   master, assembles signed 16-bit X/Y/Z samples and queues them in a
//   first-word-fall-through FIFO.
//   Optional build macro: AXIS_SIGN_EXT10_EN (store 10-bit right-justified
//   words sign-extended to 16 bits instead of the raw 16-bit word).
module adxl345_axis_assembler #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FRAME_BYTES = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cs,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    input  logic                          rd_en,
    output logic [15:0]                   x_data,
    output logic [15:0]                   y_data,
    output logic [15:0]                   z_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FRAME_BYTES);
    localparam logic [LW-1:0] DEPTH_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    // Turns a little-endian byte pair into the stored axis word.
    function automatic logic [15:0] fmt_word(input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] w;
        w = {hi, lo};
`ifdef AXIS_SIGN_EXT10_EN
        fmt_word = {{6{w[9]}}, w[9:0]};
`else
        fmt_word = w;
`endif
    endfunction

    state_t          state_r, state_n_s;
    logic            cs_q_r;
    logic            fall_s, rise_s;
    logic            start_s, ferr_s;
    logic [CW-1:0]   count_r;
    logic            bad_r;
    logic [7:0]      slot_r [FRAME_BYTES];
    logic [47:0]     mem_r  [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r, rd_ptr_n_s;
    logic [LW-1:0]   level_n_s;
    logic            push_req_s, do_push_s, do_pop_s;
    logic [47:0]     word_s, head_n_s;

    assign fall_s = cs_q_r & ~cs;
    assign rise_s = ~cs_q_r & cs;

    // Register chip select once for edge detection; low after reset so a
    // cs already held low does not look like a new burst.
    always_ff @(posedge clk) begin
        if (rst) cs_q_r <= 1'b0;
        else     cs_q_r <= cs;
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_n_s;
    end

    // Next-state logic, frame-error decision and collection start.
    always_comb begin
        state_n_s = state_r;
        ferr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) state_n_s = ST_COLLECT;
                else        state_n_s = ST_IDLE;
            end
            ST_COLLECT: begin
                if (rise_s) begin
                    if ((count_r == FULL_CNT) && !bad_r) begin
                        state_n_s = ST_COMMIT;
                    end else begin
                        state_n_s = ST_IDLE;
                        ferr_s    = 1'b1;
                    end
                end else begin
                    state_n_s = ST_COLLECT;
                end
            end
            ST_COMMIT: begin
                // A new burst may already begin while this one is pushed.
                if (fall_s) state_n_s = ST_COLLECT;
                else        state_n_s = ST_IDLE;
            end
            default: state_n_s = ST_IDLE;
        endcase
        start_s = (state_n_s == ST_COLLECT) && (state_r != ST_COLLECT);
    end

    // Byte counter and bad-frame flag for the burst being collected.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
            bad_r   <= 1'b0;
        end else if (start_s) begin
            count_r <= {CW{1'b0}};
            bad_r   <= 1'b0;
        end else if ((state_r == ST_COLLECT) && byte_valid) begin
            if (count_r < FULL_CNT) count_r <= count_r + CW'(1);
            else                    bad_r   <= 1'b1;
        end
    end

    // Byte slots written in arrival order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FRAME_BYTES; i++) slot_r[i] <= 8'h00;
        end else if ((state_r == ST_COLLECT) && byte_valid && (count_r < FULL_CNT)) begin
            for (int i = 0; i < FRAME_BYTES; i++) begin
                if (count_r == CW'(i)) slot_r[i] <= byte_data;
            end
        end
    end

    // Frame error pulse, registered.
    always_ff @(posedge clk) begin
        if (rst) frame_err <= 1'b0;
        else     frame_err <= ferr_s;
    end

    assign word_s = {fmt_word(slot_r[1], slot_r[0]),
                     fmt_word(slot_r[3], slot_r[2]),
                     fmt_word(slot_r[5], slot_r[4])};

    // FIFO push/pop qualification and the next head entry.
    always_comb begin
        push_req_s = (state_r == ST_COMMIT);
        do_pop_s   = rd_en && !empty;
        do_push_s  = push_req_s && (!full || do_pop_s);
        level_n_s  = level + LW'(do_push_s) - LW'(do_pop_s);
        rd_ptr_n_s = rd_ptr_r + PW'(do_pop_s);
        if (level_n_s == {LW{1'b0}}) begin
            head_n_s = {x_data, y_data, z_data};
        end else if (do_push_s && (level_n_s == LW'(1))) begin
            head_n_s = word_s;
        end else begin
            head_n_s = mem_r[rd_ptr_n_s];
        end
    end

    // FIFO storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= word_s;
    end

    // FIFO pointers, occupancy flags, head registers and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level    <= {LW{1'b0}};
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            x_data   <= 16'h0000;
            y_data   <= 16'h0000;
            z_data   <= 16'h0000;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            rd_ptr_r <= rd_ptr_n_s;
            level    <= level_n_s;
            empty    <= (level_n_s == {LW{1'b0}});
            full     <= (level_n_s == DEPTH_LVL);
            if (push_req_s && !do_push_s) overflow <= 1'b1;
            {x_data, y_data, z_data} <= head_n_s;
        end
    end

endmodule
